// File: rtl/mc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mc_ctrl_pkg
// Description : Shared definitions for the multi-cycle MIPS control FSM:
//               opcodes, FSM states, datapath mux codes and fault codes.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package mc_ctrl_pkg;

    // Base opcodes
    localparam logic [5:0] c_op_rtype = 6'b000000;
    localparam logic [5:0] c_op_j     = 6'b000010;
    localparam logic [5:0] c_op_beq   = 6'b000100;
    localparam logic [5:0] c_op_addi  = 6'b001000;
    localparam logic [5:0] c_op_addiu = 6'b001001;
    localparam logic [5:0] c_op_lui   = 6'b001111;
    localparam logic [5:0] c_op_lb    = 6'b100000;
    localparam logic [5:0] c_op_lh    = 6'b100001;
    localparam logic [5:0] c_op_lw    = 6'b100011;
    localparam logic [5:0] c_op_lbu   = 6'b100100;
    localparam logic [5:0] c_op_lhu   = 6'b100101;
    localparam logic [5:0] c_op_sb    = 6'b101000;
    localparam logic [5:0] c_op_sh    = 6'b101001;
    localparam logic [5:0] c_op_sw    = 6'b101011;

    // Extended ALU opcodes (R-type style operands, op selected via new_select)
    localparam logic [5:0] c_op_ext1  = 6'b111111;
    localparam logic [5:0] c_op_ext2  = 6'b011111;
    localparam logic [5:0] c_op_ext3  = 6'b101111;
    localparam logic [5:0] c_op_ext4  = 6'b110111;
    localparam logic [5:0] c_op_ext5  = 6'b111011;
    localparam logic [5:0] c_op_ext6  = 6'b111101;

    localparam logic [2:0] c_nsel_none = 3'b000;
    localparam logic [2:0] c_nsel_ext1 = 3'b001;
    localparam logic [2:0] c_nsel_ext2 = 3'b010;
    localparam logic [2:0] c_nsel_ext3 = 3'b011;
    localparam logic [2:0] c_nsel_ext4 = 3'b100;
    localparam logic [2:0] c_nsel_ext5 = 3'b101;
    localparam logic [2:0] c_nsel_ext6 = 3'b110;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_FETCH   = 4'd1,
        ST_DECODE  = 4'd2,
        ST_MEMADDR = 4'd3,
        ST_MEMRD   = 4'd4,
        ST_MEMWB   = 4'd5,
        ST_MEMWR   = 4'd6,
        ST_EXEC    = 4'd7,
        ST_ALUWB   = 4'd8,
        ST_BRANCH  = 4'd9,
        ST_JUMP    = 4'd10,
        ST_LUI     = 4'd11,
        ST_HALT    = 4'd12
    } state_t;

    // alu_src_b
    localparam logic [1:0] c_asb_rt      = 2'b00;
    localparam logic [1:0] c_asb_four    = 2'b01;
    localparam logic [1:0] c_asb_imm     = 2'b10;
    localparam logic [1:0] c_asb_imm_sl2 = 2'b11;

    // alu_op
    localparam logic [1:0] c_aop_add   = 2'b00;
    localparam logic [1:0] c_aop_sub   = 2'b01;
    localparam logic [1:0] c_aop_funct = 2'b10;

    // pc_source
    localparam logic [1:0] c_pcs_alu    = 2'b00;
    localparam logic [1:0] c_pcs_aluout = 2'b01;
    localparam logic [1:0] c_pcs_jump   = 2'b10;

    // mem_to_reg
    localparam logic [2:0] c_m2r_word = 3'b000;
    localparam logic [2:0] c_m2r_half = 3'b001;
    localparam logic [2:0] c_m2r_byte = 3'b010;
    localparam logic [2:0] c_m2r_lui  = 3'b011;
    localparam logic [2:0] c_m2r_alu  = 3'b100;

    // reg_to_mem
    localparam logic [1:0] c_r2m_word = 2'b00;
    localparam logic [1:0] c_r2m_half = 2'b01;
    localparam logic [1:0] c_r2m_byte = 2'b10;

    // fault
    localparam logic [1:0] c_fault_none    = 2'b00;
    localparam logic [1:0] c_fault_illegal = 2'b01;
    localparam logic [1:0] c_fault_timeout = 2'b10;

endpackage
`default_nettype wire

// File: rtl/mc_opcode_decode.sv
`default_nettype none
// ============================================================================
// Module      : mc_opcode_decode
// Description : Combinational opcode classifier. Produces one-hot class flags
//               and the extended-op select code.
// Ports       : op         - instruction opcode
//               is_load    - lb/lh/lw/lbu/lhu
//               is_store   - sb/sh/sw
//               is_alu     - R-type, addi/addiu, extended ops
//               is_funct   - R-type or extended op (register operand, funct ALU)
//               is_branch  - beq
//               is_jump    - j
//               is_lui     - lui
//               is_illegal - none of the above
//               new_select - extended-op code (000 when not extended)
// Revision    : 1.0 - initial release
// ============================================================================
module mc_opcode_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] op,
    output logic       is_load,
    output logic       is_store,
    output logic       is_alu,
    output logic       is_funct,
    output logic       is_branch,
    output logic       is_jump,
    output logic       is_lui,
    output logic       is_illegal,
    output logic [2:0] new_select
);

    always_comb begin
        is_load    = 1'b0;
        is_store   = 1'b0;
        is_alu     = 1'b0;
        is_funct   = 1'b0;
        is_branch  = 1'b0;
        is_jump    = 1'b0;
        is_lui     = 1'b0;
        is_illegal = 1'b0;
        new_select = c_nsel_none;
        case (op)
            c_op_lb, c_op_lh, c_op_lw, c_op_lbu, c_op_lhu: is_load  = 1'b1;
            c_op_sb, c_op_sh, c_op_sw:                     is_store = 1'b1;
            c_op_addi, c_op_addiu:                         is_alu   = 1'b1;
            c_op_beq:                                      is_branch = 1'b1;
            c_op_j:                                        is_jump  = 1'b1;
            c_op_lui:                                      is_lui   = 1'b1;
            c_op_rtype: begin
                is_alu   = 1'b1;
                is_funct = 1'b1;
            end
            c_op_ext1, c_op_ext2, c_op_ext3,
            c_op_ext4, c_op_ext5, c_op_ext6: begin
                is_alu   = 1'b1;
                is_funct = 1'b1;
                case (op)
                    c_op_ext1: new_select = c_nsel_ext1;
                    c_op_ext2: new_select = c_nsel_ext2;
                    c_op_ext3: new_select = c_nsel_ext3;
                    c_op_ext4: new_select = c_nsel_ext4;
                    c_op_ext5: new_select = c_nsel_ext5;
                    default:   new_select = c_nsel_ext6;
                endcase
            end
            default: is_illegal = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control
// Description : Multi-cycle MIPS control FSM for a shared instruction/data
//               memory datapath. Sequences fetch/decode/execute/memory/
//               writeback, waits on mem_ready with a timeout, counts retires.
// Ports       : clk, reset (async, active-high)
//               op, alu_zero, mem_ready                     - inputs
//               mem_read, mem_write, iord, ir_write, pc_write,
//               pc_write_cond, reg_write, reg_dest, alu_src_a,
//               alu_src_b, alu_op, pc_source, mem_to_reg,
//               load_signed, reg_to_mem, new_select          - datapath controls
//               instr_done, retired, halted, fault           - status
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control
    import mc_ctrl_pkg::*;
#(
    parameter int WAIT_LIMIT = 16,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic             alu_zero,
    input  logic             mem_ready,
    output logic             mem_read,
    output logic             mem_write,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             reg_write,
    output logic             reg_dest,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic [2:0]       mem_to_reg,
    output logic             load_signed,
    output logic [1:0]       reg_to_mem,
    output logic [2:0]       new_select,
    output logic             instr_done,
    output logic [CNT_W-1:0] retired,
    output logic             halted,
    output logic [1:0]       fault
);

    localparam int WCW = (WAIT_LIMIT > 2) ? $clog2(WAIT_LIMIT) : 1;
    localparam logic [WCW-1:0] c_wait_last = WCW'(WAIT_LIMIT - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [1:0]       r_fault;
    logic [1:0]       w_fault_next;
    logic [WCW-1:0]   r_wait_cnt;
    logic [CNT_W-1:0] r_retired;

    logic       w_is_load, w_is_store, w_is_alu, w_is_funct;
    logic       w_is_branch, w_is_jump, w_is_lui, w_is_illegal;
    logic [2:0] w_new_select;
    logic [2:0] w_load_m2r;
    logic       w_load_signed;
    logic [1:0] w_store_r2m;
    logic       w_in_wait;
    logic       w_wait_expired;

    // Branch qualification lives in the datapath; the flag is not needed here.
    logic w_unused_alu_zero;
    assign w_unused_alu_zero = alu_zero;

    mc_opcode_decode u_decode (
        .op         (op),
        .is_load    (w_is_load),
        .is_store   (w_is_store),
        .is_alu     (w_is_alu),
        .is_funct   (w_is_funct),
        .is_branch  (w_is_branch),
        .is_jump    (w_is_jump),
        .is_lui     (w_is_lui),
        .is_illegal (w_is_illegal),
        .new_select (w_new_select)
    );

    // Sub-word load/store formatting selects
    always_comb begin
        w_load_m2r    = c_m2r_word;
        w_load_signed = 1'b0;
        w_store_r2m   = c_r2m_word;
        case (op)
            c_op_lb:  begin w_load_m2r = c_m2r_byte; w_load_signed = 1'b1; end
            c_op_lbu: w_load_m2r = c_m2r_byte;
            c_op_lh:  begin w_load_m2r = c_m2r_half; w_load_signed = 1'b1; end
            c_op_lhu: w_load_m2r = c_m2r_half;
            c_op_sb:  w_store_r2m = c_r2m_byte;
            c_op_sh:  w_store_r2m = c_r2m_half;
            default:  ;
        endcase
    end

    assign w_in_wait = (r_state == ST_FETCH) || (r_state == ST_MEMRD) ||
                       (r_state == ST_MEMWR);
    // A ready on the final allowed cycle still completes the request.
    assign w_wait_expired = w_in_wait && !mem_ready && (r_wait_cnt == c_wait_last);

    // Next-state and per-state outputs
    always_comb begin
        w_state_next  = r_state;
        w_fault_next  = r_fault;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        iord          = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        reg_write     = 1'b0;
        reg_dest      = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = c_asb_rt;
        alu_op        = c_aop_add;
        pc_source     = c_pcs_alu;
        mem_to_reg    = c_m2r_word;
        load_signed   = 1'b0;
        reg_to_mem    = c_r2m_word;
        new_select    = c_nsel_none;
        instr_done    = 1'b0;
        halted        = 1'b0;

        case (r_state)
            ST_IDLE: w_state_next = ST_FETCH;

            ST_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = c_asb_four;
                if (mem_ready) begin
                    ir_write     = 1'b1;
                    pc_write     = 1'b1;
                    w_state_next = ST_DECODE;
                end else if (w_wait_expired) begin
                    w_state_next = ST_HALT;
                    w_fault_next = c_fault_timeout;
                end
            end

            ST_DECODE: begin
                // Precompute the branch target into ALUOut.
                alu_src_b = c_asb_imm_sl2;
                if (w_is_load || w_is_store) begin
                    w_state_next = ST_MEMADDR;
                end else if (w_is_alu) begin
                    w_state_next = ST_EXEC;
                end else if (w_is_branch) begin
                    w_state_next = ST_BRANCH;
                end else if (w_is_jump) begin
                    w_state_next = ST_JUMP;
                end else if (w_is_lui) begin
                    w_state_next = ST_LUI;
                end else if (w_is_illegal) begin
                    w_state_next = ST_HALT;
                    w_fault_next = c_fault_illegal;
                end
            end

            ST_MEMADDR: begin
                alu_src_a    = 1'b1;
                alu_src_b    = c_asb_imm;
                w_state_next = w_is_store ? ST_MEMWR : ST_MEMRD;
            end

            ST_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready) begin
                    w_state_next = ST_MEMWB;
                end else if (w_wait_expired) begin
                    w_state_next = ST_HALT;
                    w_fault_next = c_fault_timeout;
                end
            end

            ST_MEMWB: begin
                reg_write    = 1'b1;
                mem_to_reg   = w_load_m2r;
                load_signed  = w_load_signed;
                instr_done   = 1'b1;
                w_state_next = ST_FETCH;
            end

            ST_MEMWR: begin
                mem_write  = 1'b1;
                iord       = 1'b1;
                reg_to_mem = w_store_r2m;
                if (mem_ready) begin
                    instr_done   = 1'b1;
                    w_state_next = ST_FETCH;
                end else if (w_wait_expired) begin
                    w_state_next = ST_HALT;
                    w_fault_next = c_fault_timeout;
                end
            end

            ST_EXEC: begin
                alu_src_a  = 1'b1;
                new_select = w_new_select;
                if (w_is_funct) begin
                    alu_src_b = c_asb_rt;
                    alu_op    = c_aop_funct;
                end else begin
                    alu_src_b = c_asb_imm;
                    alu_op    = c_aop_add;
                end
                w_state_next = ST_ALUWB;
            end

            ST_ALUWB: begin
                reg_write    = 1'b1;
                reg_dest     = w_is_funct;
                mem_to_reg   = c_m2r_alu;
                new_select   = w_new_select;
                instr_done   = 1'b1;
                w_state_next = ST_FETCH;
            end

            ST_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_src_b     = c_asb_rt;
                alu_op        = c_aop_sub;
                pc_write_cond = 1'b1;
                pc_source     = c_pcs_aluout;
                instr_done    = 1'b1;
                w_state_next  = ST_FETCH;
            end

            ST_JUMP: begin
                pc_write     = 1'b1;
                pc_source    = c_pcs_jump;
                instr_done   = 1'b1;
                w_state_next = ST_FETCH;
            end

            ST_LUI: begin
                reg_write    = 1'b1;
                mem_to_reg   = c_m2r_lui;
                instr_done   = 1'b1;
                w_state_next = ST_FETCH;
            end

            ST_HALT: halted = 1'b1;

            default: w_state_next = ST_IDLE;
        endcase
    end

    // State, fault and memory-wait counter. The wait counter restarts on every
    // state change, so it is zero on entry to any of the waiting states.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_fault    <= c_fault_none;
            r_wait_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            r_fault <= w_fault_next;
            if (w_state_next != r_state) begin
                r_wait_cnt <= '0;
            end else if (w_in_wait && !mem_ready) begin
                r_wait_cnt <= r_wait_cnt + WCW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_retired <= '0;
        end else if (instr_done) begin
            r_retired <= r_retired + CNT_W'(1);
        end
    end

    assign retired = r_retired;
    assign fault   = r_fault;

endmodule
`default_nettype wire
